// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types, state encoding and helpers for the BCD digit
//               streamer and its double-dabble adjust cell.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SCAN = 2'd2,
        ST_EMIT = 2'd3
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    // Iteration counter width; covers BIN_W up to 256.
    localparam int SHIFT_CNT_W = 8;

    function automatic int max_val(input int ndigits);
        int v;
        v = 1;
        for (int i = 0; i < ndigits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dabble_adjust.sv
`default_nettype none
// ============================================================================
// Module      : dabble_adjust
// Description : Double-dabble correction cell: adds 3 to a BCD nibble >= 5.
// Revision    : 1.0 - initial release
// ============================================================================
module dabble_adjust
    import bcd_pkg::*;
(
    input  bcd_digit_t i_nib,
    output bcd_digit_t o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? bcd_digit_t'(i_nib + 4'd3) : i_nib;

endmodule
`default_nettype wire

// File: rtl/bcd_digit_streamer.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_streamer
// Description : Binary-to-BCD converter (iterative double dabble) that streams
//               decimal digits MSB first with leading zeros suppressed.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_streamer
    import bcd_pkg::*;
#(
    parameter int BIN_W   = 14,
    parameter int NDIGITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [BIN_W-1:0] i_in_bin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [3:0]       o_out_bcd,
    output logic             o_out_first,
    output logic             o_out_last,
    output logic             o_out_ovf
);

    localparam int MAX_VAL = max_val(NDIGITS);
    localparam int BCD_W   = 4 * NDIGITS;
    localparam int PTR_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [BIN_W-1:0]       c_max_val   = BIN_W'(MAX_VAL);
    localparam logic [SHIFT_CNT_W-1:0] c_last_iter = SHIFT_CNT_W'(BIN_W - 1);

    localparam logic [1:0] c_st_idle = ST_IDLE;
    localparam logic [1:0] c_st_conv = ST_CONV;
    localparam logic [1:0] c_st_scan = ST_SCAN;
    localparam logic [1:0] c_st_emit = ST_EMIT;

    if ((BIN_W < $clog2(MAX_VAL + 1)) || (BIN_W > (1 << SHIFT_CNT_W))) begin : g_width_check
        $error("bcd_digit_streamer: BIN_W incompatible with NDIGITS or counter width");
    end

    logic [1:0]             r_state;
    logic [BIN_W-1:0]       r_bin;
    logic [BCD_W-1:0]       r_bcd;
    logic [SHIFT_CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0]       r_ptr;
    logic                   r_ovf;
    logic                   r_out_valid;
    bcd_digit_t             r_out_bcd;
    logic                   r_out_first;
    logic                   r_out_last;
    logic                   r_out_ovf;

    logic [BCD_W-1:0]       w_bcd_adj;
    logic [BCD_W+BIN_W-1:0] w_shift;
    logic [PTR_W-1:0]       w_top_ptr;
    logic [PTR_W-1:0]       w_next_ptr;
    bcd_digit_t             w_cur_digit;
    bcd_digit_t             w_next_digit;

    for (genvar g = 0; g < NDIGITS; g++) begin : g_adj
        dabble_adjust u_adj (
            .i_nib (r_bcd[4*g +: 4]),
            .o_nib (w_bcd_adj[4*g +: 4])
        );
    end

    assign w_shift = {w_bcd_adj, r_bin} << 1;

    // Ascending scan so the highest nonzero nibble wins; all-zero leaves 0.
    always_comb begin
        w_top_ptr = '0;
        for (int i = 1; i < NDIGITS; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_top_ptr = PTR_W'(i);
            end
        end
    end

    assign w_next_ptr   = r_ptr - PTR_W'(1);
    assign w_cur_digit  = r_bcd[4*r_ptr +: 4];
    assign w_next_digit = r_bcd[4*w_next_ptr +: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_bcd   <= '0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (i_in_valid) begin
                        r_bin   <= (i_in_bin > c_max_val) ? c_max_val : i_in_bin;
                        r_ovf   <= (i_in_bin > c_max_val);
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= c_st_conv;
                    end
                end
                c_st_conv: begin
                    r_bcd <= w_shift[BCD_W+BIN_W-1:BIN_W];
                    r_bin <= w_shift[BIN_W-1:0];
                    r_cnt <= r_cnt + SHIFT_CNT_W'(1);
                    if (r_cnt == c_last_iter) begin
                        r_state <= c_st_scan;
                    end
                end
                c_st_scan: begin
                    r_ptr   <= w_top_ptr;
                    r_state <= c_st_emit;
                end
                c_st_emit: begin
                    // First EMIT cycle loads the leading digit into the output registers.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_bcd   <= w_cur_digit;
                        r_out_first <= 1'b1;
                        r_out_last  <= (r_ptr == '0);
                        r_out_ovf   <= r_ovf;
                    end else if (i_out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_bcd   <= '0;
                            r_out_first <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_ovf   <= 1'b0;
                            r_state     <= c_st_idle;
                        end else begin
                            r_ptr       <= w_next_ptr;
                            r_out_bcd   <= w_next_digit;
                            r_out_first <= 1'b0;
                            r_out_last  <= (w_next_ptr == '0);
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign o_in_ready  = (r_state == c_st_idle);
    assign o_out_valid = r_out_valid;
    assign o_out_bcd   = r_out_bcd;
    assign o_out_first = r_out_first;
    assign o_out_last  = r_out_last;
    assign o_out_ovf   = r_out_ovf;

endmodule
`default_nettype wire
